// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the word-addressed memory responder.
package mem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    // The data path is fixed at four byte lanes.
    localparam int DATA_W_FIXED = 32;
    localparam int BYTES        = DATA_W_FIXED / 8;

    // Wait-state counter width; covers WAIT_CYCLES up to 15.
    localparam int WCNT_W = 4;

endpackage : mem_pkg

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the memory responder.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. On the request channel the fields are sampled
// only at that edge. On the response channel, once rsp_valid is 1 it stays 1
// with rsp_rdata/rsp_err stable until the edge where rsp_ready is 1; a
// rsp_ready seen while rsp_valid is 0 has no effect.
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // Initiator side (control FSM / testbench).
    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_be,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    // Responder side.
    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_be,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );

endinterface : mem_responder_if

// File: rtl/mem_responder_mem_array.sv
// Word storage: synchronous byte-masked write, combinational read, no reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BYTES-1:0]  be,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write only the byte lanes whose enable is set; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule : mem_array

// File: rtl/mem_responder.sv
// Memory responder: accepts one request at a time, inserts WAIT_CYCLES wait
// states, executes the access in a single EXEC cycle and holds the response
// until the initiator takes it.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output state_t          dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    // Registered state.
    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]    be_q, be_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                rsp_valid_q, rsp_valid_d;

    // Decoded from the latched request.
    logic                addr_err;
    logic [IDX_W-1:0]    widx;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    // Word index uses only the bits that address storage.
    assign widx = addr_q[IDX_W+1:2];

    // DEPTH is a power of two, so any set bit above the word index means the
    // word lies beyond the end of storage.
    assign addr_err = (addr_q[1:0] != 2'b00) || (|addr_q[ADDR_W-1:IDX_W+2]);

    // Storage is touched only in EXEC, and only for error-free writes. A zero
    // byte-enable still passes through and simply changes no lane.
    assign mem_we = (state_q == EXEC) && we_q && !addr_err;

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (be_q),
        .widx  (widx),
        .wdata (wdata_q),
        .ridx  (widx),
        .rdata (mem_rdata)
    );

    // Next-state and next-register computation for the responder FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = WCNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? EXEC : WAIT;
                end
            end

            WAIT: begin
                cnt_d = cnt_q - WCNT_W'(1);
                if (cnt_q == WCNT_W'(1)) begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                // Reads return storage; writes and errors return zero.
                rdata_d     = (!we_q && !addr_err) ? mem_rdata : '0;
                err_d       = addr_err;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end

            RESP: begin
                // New requests wait until the cycle after this handshake.
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; storage itself is not reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model with per-cycle compare,
// directed literal checks, randomized traffic, and a zero-wait-state instance.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int WC    = 2;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  state_t dbg_state;
  state_t dbg_state0;

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .dbg_state (dbg_state0)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no event within bound, required event", name);
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding transaction. It executes WC+1 edges after the accept edge
  // (that is when storage changes and the response appears) and retires at
  // the first later edge with rsp_ready=1.
  logic [31:0] mem_m [DEPTH];
  bit          m_pend = 1'b0;
  int          m_age  = 0;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        cmp_ev;
  logic [31:0] exp_q [$];

  task automatic model_exec();
    m_err = (m_addr % 4 != 0) || (m_addr / 4 >= DEPTH);
    m_rdata = 32'h0;
    if (!m_err) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem_m[m_addr / 4][8*b +: 8] = m_wdata[8*b +: 8];
      end else begin
        m_rdata = mem_m[m_addr / 4];
      end
    end
    exp_q.push_back(m_rdata);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      if (m_pend && m_age >= WC + 1 && bus.rsp_ready) begin
        m_pend = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (!m_pend && bus.req_valid) begin
        m_pend  = 1'b1;
        m_age   = 0;
        m_we    = bus.req_we;
        m_addr  = bus.req_addr;
        m_wdata = bus.req_wdata;
        m_be    = bus.req_be;
      end else if (m_pend) begin
        m_age++;
        if (m_age == WC + 1) model_exec();
      end
    end
  end

  // Abandon any transaction on reset.
  always @(negedge reset) begin
    m_pend = 1'b0;
    exp_q.delete();
  end

  // Per-cycle compare of the main instance against the model.
  always @(negedge clk) begin
    if (reset) begin
      cmp_ev = m_pend && (m_age >= WC + 1);
      check("rsp_valid", bus.rsp_valid, cmp_ev);
      check("req_ready", bus.req_ready, !m_pend);
      if (cmp_ev) begin
        check("rsp_rdata", bus.rsp_rdata, m_rdata);
        check("rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Runs one transaction with rsp_ready=1. lat counts edges from the accept
  // edge (counted as 1) to the edge after which rsp_valid is seen high.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    int guard;
    rd = '0; er = 1'b0; lat = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.rsp_ready = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!bus.req_ready) begin
      fail_now("accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble the fields after acceptance; they must be ignored.
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.rsp_valid) begin
      fail_now("rsp_timeout");
      return;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk); #1;
  endtask

  // Zero-wait-state stimulus table.
  logic        t_we   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] t_addr [7] = '{32'h4, 32'h8, 32'h8, 32'h4, 32'h8, 32'h6, 32'h100};
  logic [31:0] t_wd   [7] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [3:0]  t_be   [7] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [31:0] t_erd  [7] = '{32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0};
  logic        t_eer  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic set_bus0(input int i);
    bus0.req_we    = t_we[i];
    bus0.req_addr  = t_addr[i];
    bus0.req_wdata = t_wd[i];
    bus0.req_be    = t_be[i];
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;
    int          acc [7];
    int          rise [7];
    logic [31:0] rd0 [7];
    logic        er0 [7];
    int          idx, r, cyc;
    logic        rdy, pv;
    logic [31:0] a;
    int          sel;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_be = '0; bus.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.req_be = '0; bus0.rsp_ready = 1'b1;

    // Reset values.
    #2 reset = 1'b0;
    #1;
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err", bus.rsp_err, 1'b0);
    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_req_ready0", bus0.req_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Fill storage so every later read has a known value.
    for (int w = 0; w < DEPTH; w++) do_txn(1'b1, 32'(w * 4), $urandom, 4'hF, rd, er, lat);

    // Basic write then read with latency.
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("wr_rdata", rd, 32'h0);
    check("wr_err", er, 1'b0);
    check("wr_latency", lat, 4);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("rd_rdata", rd, 32'hDEADBEEF);
    check("rd_err", er, 1'b0);
    check("rd_latency", lat, 4);

    // Byte-enable merge.
    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("be_merge", rd, 32'h11BB33DD);

    // Errors.
    do_txn(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    check("misalign_err", er, 1'b1);
    check("misalign_rdata", rd, 32'h0);
    do_txn(1'b1, 32'h0, 32'h0BADC0DE, 4'hF, rd, er, lat);
    do_txn(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("range_err", er, 1'b1);
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("range_no_alias", rd, 32'h0BADC0DE);

    // Backpressure: response held, early request parked on the bus.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h20; bus.req_be = 4'h0;
    @(posedge clk); #1;
    bus.req_addr = 32'h10;
    guard = 0;
    while (!bus.rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!bus.rsp_valid) fail_now("bp_rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_rsp_rdata", bus.rsp_rdata, 32'h11BB33DD);
      check("bp_rsp_err", bus.rsp_err, 1'b0);
      check("bp_req_ready", bus.req_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_rsp_valid_drop", bus.rsp_valid, 1'b0);
    check("hs_no_accept", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    check("hs_accept_next", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!bus.rsp_valid) fail_now("bp2_rsp_timeout");
    check("bp2_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset in the middle of a write.
    do_txn(1'b1, 32'h8, 32'h12345678, 4'hF, rd, er, lat);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h8;
    bus.req_wdata = 32'hCAFEF00D; bus.req_be = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_req_ready", bus.req_ready, 1'b1);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1 reset = 1'b1;
    do_txn(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check("mid_rst_no_write", rd, 32'h12345678);

    // Randomized traffic with backpressure.
    for (int c = 0; c < 1500; c++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(DEPTH, 4 * DEPTH) * 4);
      else               a = $urandom;
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = a;
      bus.req_wdata = $urandom;
      bus.req_be    = 4'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Zero wait states, back-to-back with valid/ready held high.
    idx = 0; r = 0; cyc = 0;
    set_bus0(0);
    bus0.req_valid = 1'b1;
    bus0.rsp_ready = 1'b1;
    while (r < 7 && cyc < 60) begin
      rdy = bus0.req_ready;
      pv  = bus0.rsp_valid;
      @(posedge clk); cyc++; #1;
      if (rdy && idx < 7) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 7) set_bus0(idx);
        else bus0.req_valid = 1'b0;
      end
      if (!pv && bus0.rsp_valid) begin
        rise[r] = cyc;
        rd0[r]  = bus0.rsp_rdata;
        er0[r]  = bus0.rsp_err;
        r++;
      end
    end
    if (r < 7) fail_now("wc0_timeout");
    for (int i = 0; i < r; i++) begin
      check("wc0_latency", rise[i] - acc[i] + 1, 2);
      check("wc0_rdata", rd0[i], t_erd[i]);
      check("wc0_err", er0[i], t_eer[i]);
      if (i > 0) check("wc0_period", acc[i] - acc[i-1], 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound on simulated time.
  initial begin
    #600000;
    fail_now("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "simulation time bound reached");
  end

endmodule : tb_mem_responder

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed data-memory responder that sits on the far side of the multicycle datapath's memory port.
- It accepts read/write requests over a valid/ready handshake, inserts a fixed number of wait states, and returns a response over a second valid/ready handshake.
- It lets the control FSM be exercised against a non-ideal memory with stalls, byte-enable writes and error reporting.

Parameters:
- ADDR_W, 32, request byte-address width
- DATA_W, 32, data width; must be 32 (4 byte lanes)
- DEPTH, 64, number of words in storage; power of two
- WAIT_CYCLES, 2, wait states inserted between accept and response; range 0..15

Ports:
- clk  input  1  single clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  write data
- req_be  input  4  byte enables for writes; bit i selects byte lane i
- rsp_valid  output  1  response available
- rsp_ready  input  1  initiator consumes the response
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors
- rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - req_ready=1, because it is decoded from IDLE.
  - Memory contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid=1, latch we/addr/wdata/be; load counter=WAIT_CYCLES; go to WAIT, or go directly to EXEC if WAIT_CYCLES=0.
  - WAIT: req_ready=0. Counter decrements each cycle; when counter==1, go to EXEC.
  - EXEC: one cycle, req_ready=0.
    - Error check: err = (addr[1:0]!=0) or (addr[ADDR_W-1:2] >= DEPTH).
    - Write without error: update only the bytes whose be bit is 1.
    - Read without error: rdata register <= mem[addr>>2].
    - Write or error: rdata register <= 0.
    - err register <= err. Go to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable. On rsp_ready=1, go to IDLE, and rsp_valid drops the next cycle.
- Latency:
  - rsp_valid rises exactly WAIT_CYCLES+2 edges after the accept edge.
  - With WAIT_CYCLES=0, it rises 2 edges after accept.
- Throughput:
  - A request is never accepted in the same cycle a response handshakes; req_ready returns the cycle after.
  - Minimum period is WAIT_CYCLES+3 cycles per transaction.
- Handshake rules:
  - Request fields are sampled only at the accept edge; later changes are ignored.
  - rsp_valid, once high, stays high until rsp_ready=1.
  - rsp_ready while rsp_valid=0 is ignored.
- Write with be=4'b0000: no storage change, err per the address check, normal response.
- Reset mid-operation: the transaction is abandoned. A write that has not reached EXEC is not performed; no response is issued.
- Word index = addr[$clog2(DEPTH)+1:2]; higher bits participate only in the range check.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, WAIT, EXEC, RESP}
  - BYTES = DATA_W/8
  - WCNT_W = 4
- Sub-module mem_array (DEPTH x DATA_W, synchronous byte-masked write, combinational read):
  - Ports clk, we, be, widx, wdata, ridx, rdata; no reset.
- mem_responder holds the FSM, the request latch, the wait counter and the response registers.

Test Plan:
- Reset, then write addr=0x10, wdata=0xDEADBEEF, be=4'hF; read addr=0x10 (WAIT_CYCLES=2) -> write rsp after 4 edges, err=0, rdata=0; read rsp rdata=0xDEADBEEF, rsp_valid rising 4 edges after accept.
- Byte-enable merge: write 0x11223344 be=F to 0x20, then write 0xAABBCCDD be=4'b0101 to 0x20; read 0x20 -> rdata=0x11BB33DD.
- Errors: read addr=0x22 -> err=1, rdata=0. Write addr=0x100 (word 64, DEPTH=64) -> err=1, and a later read of 0x0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rdata and err stay stable and req_ready stays 0. A request on req_valid during RESP is not accepted until the cycle after the rsp_ready handshake.
- WAIT_CYCLES=0 variant: back-to-back reads with req_valid and rsp_ready held at 1 -> one transaction every 3 cycles, rsp_valid 2 edges after each accept.
- Reset mid-operation: accept write 0xCAFEF00D to 0x8, drop reset during WAIT -> rsp_valid=0 and req_ready=1 immediately (asynchronous). A prior value 0x12345678 at 0x8 still reads back after reset releases.
